elem_result_sink: RTL and testbench

//  Receiving end of the element-wise ALU result stream (out/out_valid/out_last of

---
 rtl/elem_result_sink.sv | 108 ++++++++++
 tb/tb_elem_result_sink.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/elem_result_sink.sv
// Result-stream sink: captures one vector of element results into result RAM
// at base_addr+index, checks its length, and pulses done when the last beat lands.
module elem_result_sink #(
  parameter int ID       = 0,
  parameter bit SIM_MODE = 1'b0,
  parameter int ADDR_W   = 12,
  parameter int FSIZE    = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   exp_len,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic [FSIZE-1:0]  in_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [FSIZE-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err_len,
  output logic              err_stray,
  output logic [1:0]        state_dbg
);

  // Stream handshake: in_valid alone qualifies a beat (there is no ready);
  // every beat is consumed in the cycle it is presented.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] CNT_MAX = '1;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W+1:0]   count_inc;
  logic                beat_recv;
  logic                in_range;
  logic                arm;
  logic                unused_params;

  assign unused_params = (ID != 0) ^ SIM_MODE;

  assign beat_recv = (state == S_RECV) && in_valid;
  assign in_range  = (count < len_q);
  assign arm       = (state == S_IDLE) && start;
  assign count_inc = {1'b0, count} + {{(ADDR_W+1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RECV;
      S_RECV:  if (in_valid && in_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base_q    <= '0;
      len_q     <= '0;
      count     <= '0;
      err_len   <= 1'b0;
      err_stray <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_en <= beat_recv && in_range;
      if (beat_recv && in_range) begin
        wr_addr <= base_q + count[ADDR_W-1:0];
        wr_data <= in_data;
      end
      if (arm) begin
        base_q    <= base_addr;
        len_q     <= exp_len;
        count     <= '0;
        err_len   <= 1'b0;
        // A beat coincident with start still belongs to no vector.
        err_stray <= in_valid;
      end else begin
        if (in_valid && (state != S_RECV)) err_stray <= 1'b1;
        if (beat_recv) begin
          if (count != CNT_MAX) count <= count_inc[ADDR_W:0];
          if (!in_range) err_len <= 1'b1;
          if (in_last && (count_inc != {1'b0, len_q})) err_len <= 1'b1;
        end
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_elem_result_sink.sv
// Bench for elem_result_sink: directed scenarios plus random vectors checked
// against an expected-write queue built from the vector's base/length/beat count.
module tb_elem_result_sink;
  localparam int AW = 12;
  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   exp_len;
  logic          in_valid;
  logic          in_last;
  logic [FW-1:0] in_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [FW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic [AW:0]   count;
  logic          err_len;
  logic          err_stray;
  logic [1:0]    state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int done_seen = 0;
  logic [AW+FW-1:0] exp_q[$];

  elem_result_sink #(.ID(0), .SIM_MODE(1'b0), .ADDR_W(AW), .FSIZE(FW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .exp_len(exp_len),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .count(count), .err_len(err_len), .err_stray(err_stray), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every RAM write must match the head of the expected queue
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (wr_en === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_write got addr=%h data=%h, expected no write", wr_addr, wr_data);
        end else begin
          logic [AW+FW-1:0] e;
          e = exp_q.pop_front();
          if ({wr_addr, wr_data} !== e)
            $display("FAIL write got addr=%h data=%h, expected addr=%h data=%h",
                     wr_addr, wr_data, e[AW+FW-1:FW], e[FW-1:0]);
          else n_pass++;
        end
      end
      if (done === 1'b1) done_seen++;
    end
  end

  // drivers
  task automatic arm(input logic [AW-1:0] b, input int l, input bit with_beat);
    done_seen = 0;
    start     = 1'b1;
    base_addr = b;
    exp_len   = (AW+1)'(l);
    in_valid  = with_beat;
    in_last   = 1'b0;
    in_data   = FW'($urandom);
    step();
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  // Beats i < l land at base+i (mod 2**AW) one cycle later; the rest are dropped.
  task automatic send_beats(input logic [AW-1:0] b, input int l, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      logic [FW-1:0] d;
      if (gaps) repeat ($urandom_range(0, 2)) step();
      a = b + i[AW-1:0];
      d = FW'($urandom);
      if (i < l) exp_q.push_back({a, d});
      in_valid = 1'b1;
      in_last  = (i == n - 1);
      in_data  = d;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      n_checks++;
      if (i < l) begin
        if (wr_en !== 1'b1 || wr_addr !== a || wr_data !== d)
          $display("FAIL beat_latency beat %0d got wr_en=%b addr=%h data=%h, expected 1 %h %h",
                   i, wr_en, wr_addr, wr_data, a, d);
        else n_pass++;
      end else begin
        if (wr_en !== 1'b0) $display("FAIL overflow_write beat %0d got wr_en=%b, expected 0", i, wr_en);
        else n_pass++;
      end
    end
  endtask

  // tests
  task automatic test_reset;
    rstn = 1'b0; start = 1'b0; base_addr = '0; exp_len = '0;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    repeat (3) step();
    n_checks++;
    if ({wr_en, busy, done, count, err_len, err_stray, wr_addr, wr_data} !== '0)
      $display("FAIL reset_outputs got en=%b busy=%b done=%b cnt=%0d el=%b es=%b, expected all 0",
               wr_en, busy, done, count, err_len, err_stray);
    else n_pass++;
    rstn = 1'b1;
    step();
    n_checks++;
    if ({wr_en, busy, done, count, err_len, err_stray} !== '0)
      $display("FAIL post_reset_idle got en=%b busy=%b done=%b cnt=%0d, expected all 0", wr_en, busy, done, count);
    else n_pass++;
  endtask

  task automatic test_stray;
    in_valid = 1'b1; in_data = FW'($urandom);
    step();
    in_valid = 1'b0;
    n_checks++;
    if (err_stray !== 1'b1 || wr_en !== 1'b0 || count !== '0 || busy !== 1'b0)
      $display("FAIL stray_idle got es=%b en=%b cnt=%0d busy=%b, expected 1 0 0 0", err_stray, wr_en, count, busy);
    else n_pass++;
    arm(12'h040, 3, 1'b1);
    n_checks++;
    if (busy !== 1'b1 || err_stray !== 1'b1 || count !== '0 || wr_en !== 1'b0)
      $display("FAIL stray_start got busy=%b es=%b cnt=%0d en=%b, expected 1 1 0 0", busy, err_stray, count, wr_en);
    else n_pass++;
    send_beats(12'h040, 3, 3, 1'b0);
    step();
    n_checks++;
    if (count !== 13'd3 || err_len !== 1'b0 || err_stray !== 1'b1 || done_seen != 1 || exp_q.size() != 0)
      $display("FAIL stray_vector got cnt=%0d el=%b es=%b dones=%0d left=%0d, expected 3 0 1 1 0",
               count, err_len, err_stray, done_seen, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_contiguous;
    arm(12'h010, 4, 1'b0);
    send_beats(12'h010, 4, 4, 1'b0);
    n_checks++;
    if (done !== 1'b1 || wr_en !== 1'b1 || wr_addr !== 12'h013)
      $display("FAIL done_with_last got done=%b en=%b addr=%h, expected 1 1 013", done, wr_en, wr_addr);
    else n_pass++;
    step();
    n_checks++;
    if (wr_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || count !== 13'd4 ||
        err_len !== 1'b0 || err_stray !== 1'b0 || done_seen != 1 || exp_q.size() != 0)
      $display("FAIL contiguous_end got en=%b done=%b busy=%b cnt=%0d el=%b es=%b dones=%0d, expected 0 0 0 4 0 0 1",
               wr_en, done, busy, count, err_len, err_stray, done_seen);
    else n_pass++;
  endtask

  task automatic test_wrap;
    arm(12'hFFE, 4, 1'b0);
    send_beats(12'hFFE, 4, 4, 1'b1);
    step();
    n_checks++;
    if (count !== 13'd4 || err_len !== 1'b0 || done_seen != 1 || exp_q.size() != 0 || wr_addr !== 12'h001)
      $display("FAIL wrap_end got cnt=%0d el=%b dones=%0d addr=%h, expected 4 0 1 001",
               count, err_len, done_seen, wr_addr);
    else n_pass++;
  endtask

  task automatic test_short;
    arm(12'h080, 4, 1'b0);
    send_beats(12'h080, 4, 3, 1'b0);
    step();
    n_checks++;
    if (count !== 13'd3 || err_len !== 1'b1 || done_seen != 1 || exp_q.size() != 0)
      $display("FAIL short_end got cnt=%0d el=%b dones=%0d, expected 3 1 1", count, err_len, done_seen);
    else n_pass++;
    arm(12'h100, 2, 1'b0);
    n_checks++;
    if (err_len !== 1'b0 || busy !== 1'b1)
      $display("FAIL short_clear got el=%b busy=%b, expected 0 1", err_len, busy);
    else n_pass++;
    send_beats(12'h100, 2, 2, 1'b0);
    step();
    n_checks++;
    if (count !== 13'd2 || err_len !== 1'b0 || done_seen != 1)
      $display("FAIL short_next got cnt=%0d el=%b dones=%0d, expected 2 0 1", count, err_len, done_seen);
    else n_pass++;
  endtask

  task automatic test_overflow;
    arm(12'h200, 2, 1'b0);
    send_beats(12'h200, 2, 4, 1'b0);
    step();
    n_checks++;
    if (count !== 13'd4 || err_len !== 1'b1 || done_seen != 1 || exp_q.size() != 0)
      $display("FAIL overflow_end got cnt=%0d el=%b dones=%0d, expected 4 1 1", count, err_len, done_seen);
    else n_pass++;
    arm(12'h300, 0, 1'b0);
    send_beats(12'h300, 0, 2, 1'b0);
    step();
    n_checks++;
    if (count !== 13'd2 || err_len !== 1'b1 || done_seen != 1)
      $display("FAIL zero_len got cnt=%0d el=%b dones=%0d, expected 2 1 1", count, err_len, done_seen);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    arm(12'h400, 5, 1'b0);
    for (int i = 0; i < 2; i++) begin
      logic [FW-1:0] d;
      d = FW'($urandom);
      exp_q.push_back({12'h400 + i[AW-1:0], d});
      in_valid = 1'b1; in_last = 1'b0; in_data = d;
      step();
    end
    in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({wr_en, busy, done, count} !== '0)
      $display("FAIL async_reset got en=%b busy=%b done=%b cnt=%0d, expected all 0", wr_en, busy, done, count);
    else n_pass++;
    exp_q.delete();
    repeat (2) step();
    rstn = 1'b1;
    step();
    n_checks++;
    if (done_seen != 0 || busy !== 1'b0)
      $display("FAIL reset_no_done got dones=%0d busy=%b, expected 0 0", done_seen, busy);
    else n_pass++;
    arm(12'h500, 5, 1'b0);
    send_beats(12'h500, 5, 5, 1'b1);
    step();
    n_checks++;
    if (count !== 13'd5 || err_len !== 1'b0 || done_seen != 1 || exp_q.size() != 0)
      $display("FAIL after_reset_vec got cnt=%0d el=%b dones=%0d, expected 5 0 1", count, err_len, done_seen);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    for (int v = 0; v < 10; v++) begin
      logic [AW-1:0] b;
      int l, n;
      b = AW'($urandom);
      l = $urandom_range(0, 8);
      n = $urandom_range(1, 10);
      arm(b, l, 1'b0);
      send_beats(b, l, n, ($urandom_range(0, 1) == 1));
      step();
      n_checks++;
      if (count !== (AW+1)'(n) || err_len !== (n != l) || err_stray !== 1'b0 ||
          done_seen != 1 || exp_q.size() != 0 || wr_en !== 1'b0)
        $display("FAIL random_vec %0d base=%h len=%0d beats=%0d got cnt=%0d el=%b es=%b dones=%0d left=%0d",
                 v, b, l, n, count, err_len, err_stray, done_seen, exp_q.size());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_stray();
    test_contiguous();
    test_wrap();
    test_short();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
